// File: rtl/pdm_pkg.sv
// Shared constants and width helpers for the PDM capture chain
// (deserializer, PCM filter, downstream audio buffer).
package pdm_pkg;

  localparam int WORD_LENGTH = 16;

  // Width needed to hold a ones-count summed over a full averaging window.
  function automatic int sum_width(input int word_length, input int window_log2);
    return $clog2(word_length * (1 << window_log2) + 1);
  endfunction

  // Mid-scale of the window sum; subtracting it centres the PCM output on zero.
  function automatic int pcm_offset(input int word_length, input int window_log2);
    return (word_length << window_log2) / 2;
  endfunction

endpackage

// File: rtl/pdm_popcount.sv
// Combinational ones-count of one packed PDM word.
module pdm_popcount #(
  parameter int WORD_LENGTH = pdm_pkg::WORD_LENGTH,
  parameter int CNT_W       = $clog2(WORD_LENGTH + 1)
) (
  input  logic [WORD_LENGTH-1:0] data,
  output logic [CNT_W-1:0]       count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < WORD_LENGTH; i++) begin
      count = count + CNT_W'(data[i]);
    end
  end

endmodule

// File: rtl/pdm_pcm_filter.sv
// Boxcar moving-average PDM-to-PCM filter: popcount stage, running-sum stage,
// and a single-entry valid/ready output register with sticky overrun flag.
module pdm_pcm_filter #(
  parameter int WORD_LENGTH = pdm_pkg::WORD_LENGTH,
  parameter int WINDOW_LOG2 = 4,
  parameter int OUT_WIDTH   = 16
) (
  input  logic                   clock_i,
  input  logic                   reset_n_i,
  input  logic                   enable_i,
  input  logic                   done_i,
  input  logic [WORD_LENGTH-1:0] data_i,
  output logic [OUT_WIDTH-1:0]   pcm_o,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic                   overrun_o
);

  import pdm_pkg::*;

  localparam int N      = 1 << WINDOW_LOG2;
  localparam int CNT_W  = $clog2(WORD_LENGTH + 1);
  localparam int SUM_W  = sum_width(WORD_LENGTH, WINDOW_LOG2);
  localparam int OFFSET = pcm_offset(WORD_LENGTH, WINDOW_LOG2);

  logic [CNT_W-1:0]       pop_count;
  logic [CNT_W-1:0]       s1_count;
  logic                   s1_valid;
  logic [CNT_W-1:0]       hist [N];
  logic [SUM_W-1:0]       sum;
  logic [SUM_W-1:0]       sum_next;
  logic [WINDOW_LOG2-1:0] ptr;
  logic [WINDOW_LOG2:0]   warm_cnt;
  logic                   window_full;
  logic                   new_sample;
  logic [OUT_WIDTH-1:0]   pcm_next;

  pdm_popcount #(
    .WORD_LENGTH(WORD_LENGTH),
    .CNT_W      (CNT_W)
  ) u_popcount (
    .data (data_i),
    .count(pop_count)
  );

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      s1_valid <= 1'b0;
      s1_count <= '0;
    end else if (!enable_i) begin
      s1_valid <= 1'b0;
      s1_count <= '0;
    end else begin
      s1_valid <= done_i;
      s1_count <= pop_count;
    end
  end

  // The oldest entry is always part of sum, so the subtraction cannot underflow.
  always_comb begin
    sum_next    = sum + SUM_W'(s1_count) - SUM_W'(hist[ptr]);
    window_full = (warm_cnt >= (WINDOW_LOG2 + 1)'(N - 1));
    new_sample  = s1_valid && window_full;
    pcm_next    = OUT_WIDTH'(sum_next) - OUT_WIDTH'(OFFSET);
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < N; i++) hist[i] <= '0;
      sum      <= '0;
      ptr      <= '0;
      warm_cnt <= '0;
    end else if (!enable_i) begin
      for (int i = 0; i < N; i++) hist[i] <= '0;
      sum      <= '0;
      ptr      <= '0;
      warm_cnt <= '0;
    end else if (s1_valid) begin
      hist[ptr] <= s1_count;
      sum       <= sum_next;
      ptr       <= ptr + 1'b1;
      if (warm_cnt != (WINDOW_LOG2 + 1)'(N)) warm_cnt <= warm_cnt + 1'b1;
    end
  end

  // A fresh sample always wins; it only counts as overrun if the old one was stalled.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      pcm_o     <= '0;
      valid_o   <= 1'b0;
      overrun_o <= 1'b0;
    end else if (!enable_i) begin
      pcm_o     <= '0;
      valid_o   <= 1'b0;
      overrun_o <= 1'b0;
    end else if (new_sample) begin
      pcm_o   <= pcm_next;
      valid_o <= 1'b1;
      if (valid_o && !ready_i) overrun_o <= 1'b1;
    end else if (valid_o && ready_i) begin
      valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pdm_pcm_filter.sv
// Self-checking bench for pdm_pcm_filter: a reference moving-average model
// pushes expected PCM samples into a queue that is popped as the DUT emits them.
module tb_pdm_pcm_filter;

  logic        clock_i = 1'b0;
  logic        reset_n_i;
  logic        enable_i;
  logic        done_i;
  logic [15:0] data_i;
  logic [15:0] pcm_o;
  logic        valid_o;
  logic        ready_i;
  logic        overrun_o;

  int total = 0;
  int bad   = 0;
  int exp_q[$];

  int m_hist[16];
  int m_sum;
  int m_ptr;
  int m_cnt;

  always #5 clock_i = ~clock_i;

  pdm_pcm_filter #(
    .WORD_LENGTH(16),
    .WINDOW_LOG2(4),
    .OUT_WIDTH  (16)
  ) dut (
    .clock_i  (clock_i),
    .reset_n_i(reset_n_i),
    .enable_i (enable_i),
    .done_i   (done_i),
    .data_i   (data_i),
    .pcm_o    (pcm_o),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .overrun_o(overrun_o)
  );

  task automatic model_reset();
    m_hist = '{default: 0};
    m_sum  = 0;
    m_ptr  = 0;
    m_cnt  = 0;
    exp_q.delete();
  endtask

  // Reference: window of the last 16 ones-counts, sample emitted from word 16 on.
  task automatic model_word(input logic [15:0] d);
    int p;
    p = $countones(d);
    m_sum = m_sum - m_hist[m_ptr] + p;
    m_hist[m_ptr] = p;
    m_ptr = (m_ptr + 1) % 16;
    if (m_cnt < 16) m_cnt++;
    if (m_cnt == 16) exp_q.push_back(m_sum - 128);
  endtask

  task automatic send_word(input logic [15:0] d);
    @(posedge clock_i); #1;
    done_i = 1'b1;
    data_i = d;
    if (enable_i) model_word(d);
    @(posedge clock_i); #1;
    done_i = 1'b0;
  endtask

  task automatic clear_dut();
    @(posedge clock_i); #1;
    enable_i = 1'b0;
    done_i   = 1'b0;
    @(posedge clock_i); #1;
    enable_i = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    @(negedge clock_i);
    total += 3;
    if (pcm_o !== 16'h0000) begin bad++; $display("[TB] FAIL reset_pcm got=%h want=0000", pcm_o); end
    if (valid_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%b want=0", valid_o); end
    if (overrun_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_overrun got=%b want=0", overrun_o); end
    @(posedge clock_i); #1;
    reset_n_i = 1'b1;
  endtask

  task automatic test_warmup();
    int seen;
    logic [15:0] e;
    for (int w = 0; w < 16; w++) begin
      send_word(16'hFFFF);
      seen = 0;
      for (int c = 0; c < 3; c++) begin
        @(negedge clock_i);
        if (valid_o) begin
          seen++;
          total++;
          if (c != 1) begin bad++; $display("[TB] FAIL warmup_latency word=%0d valid at cycle %0d want 1", w + 1, c); end
          if (c == 1 && exp_q.size() > 0) begin
            e = 16'(exp_q.pop_front());
            total++;
            if (pcm_o !== e) begin bad++; $display("[TB] FAIL warmup_pcm got=%h want=%h", pcm_o, e); end
          end
          if (c == 1 && w == 15) begin
            total++;
            if (pcm_o !== 16'h0080) begin bad++; $display("[TB] FAIL warmup_full got=%h want=0080", pcm_o); end
          end
        end
      end
      total++;
      if (seen != ((w == 15) ? 1 : 0)) begin
        bad++;
        $display("[TB] FAIL warmup_count word=%0d got=%0d samples want=%0d", w + 1, seen, (w == 15) ? 1 : 0);
      end
    end
  endtask

  task automatic test_slide();
    logic [15:0] e;
    logic [15:0] k_exp;
    for (int ph = 0; ph < 2; ph++) begin
      for (int k = 0; k < 16; k++) begin
        send_word((ph == 0) ? 16'hAAAA : 16'h0000);
        repeat (2) @(negedge clock_i);
        k_exp = 16'(128 - 8 * (ph * 16 + k + 1));
        total += 2;
        if (valid_o !== 1'b1) begin bad++; $display("[TB] FAIL slide_valid step=%0d got=%b want=1", ph * 16 + k, valid_o); end
        if (pcm_o !== k_exp) begin bad++; $display("[TB] FAIL slide_step step=%0d got=%h want=%h", ph * 16 + k, pcm_o, k_exp); end
        if (exp_q.size() > 0) begin
          e = 16'(exp_q.pop_front());
          total++;
          if (pcm_o !== e) begin bad++; $display("[TB] FAIL slide_model got=%h want=%h", pcm_o, e); end
        end
        @(negedge clock_i);
        total++;
        if (valid_o !== 1'b0) begin bad++; $display("[TB] FAIL slide_accept got valid=%b want=0", valid_o); end
      end
    end
    total++;
    if (pcm_o !== 16'hFF80) begin bad++; $display("[TB] FAIL slide_final got=%h want=ff80", pcm_o); end
  endtask

  task automatic test_back_to_back();
    int seen;
    logic [15:0] e;
    clear_dut();
    seen = 0;
    for (int i = 0; i < 24; i++) begin
      @(posedge clock_i); #1;
      done_i = (i < 20);
      data_i = 16'h000F;
      if (i < 20) model_word(16'h000F);
      @(negedge clock_i);
      if (valid_o) begin
        seen++;
        total += 2;
        e = (exp_q.size() > 0) ? 16'(exp_q.pop_front()) : 16'hxxxx;
        if (pcm_o !== e) begin bad++; $display("[TB] FAIL b2b_model got=%h want=%h", pcm_o, e); end
        if (pcm_o !== 16'hFFC0) begin bad++; $display("[TB] FAIL b2b_steady got=%h want=ffc0", pcm_o); end
      end
    end
    done_i = 1'b0;
    total++;
    if (seen != 5) begin bad++; $display("[TB] FAIL b2b_count got=%0d want=5", seen); end
  endtask

  task automatic test_simultaneous();
    logic [15:0] e;
    ready_i = 1'b0;
    send_word(16'hFFFF);
    repeat (4) @(negedge clock_i);
    e = (exp_q.size() > 0) ? 16'(exp_q.pop_front()) : 16'hxxxx;
    total += 2;
    if (valid_o !== 1'b1) begin bad++; $display("[TB] FAIL hold_valid got=%b want=1", valid_o); end
    if (pcm_o !== e) begin bad++; $display("[TB] FAIL hold_pcm got=%h want=%h", pcm_o, e); end
    @(posedge clock_i); #1;
    done_i = 1'b1;
    data_i = 16'h0000;
    model_word(16'h0000);
    @(posedge clock_i); #1;
    done_i  = 1'b0;
    ready_i = 1'b1;
    @(posedge clock_i); #1;
    ready_i = 1'b0;
    @(negedge clock_i);
    e = (exp_q.size() > 0) ? 16'(exp_q.pop_front()) : 16'hxxxx;
    total += 3;
    if (valid_o !== 1'b1) begin bad++; $display("[TB] FAIL simul_valid got=%b want=1", valid_o); end
    if (pcm_o !== e) begin bad++; $display("[TB] FAIL simul_pcm got=%h want=%h", pcm_o, e); end
    if (overrun_o !== 1'b0) begin bad++; $display("[TB] FAIL simul_overrun got=%b want=0", overrun_o); end
  endtask

  task automatic test_backpressure();
    logic [15:0] e;
    for (int s = 0; s < 2; s++) begin
      send_word(16'hFFFF);
      repeat (2) @(negedge clock_i);
      e = (exp_q.size() > 0) ? 16'(exp_q.pop_front()) : 16'hxxxx;
      total += 3;
      if (valid_o !== 1'b1) begin bad++; $display("[TB] FAIL bp_valid sample=%0d got=%b want=1", s, valid_o); end
      if (pcm_o !== e) begin bad++; $display("[TB] FAIL bp_pcm sample=%0d got=%h want=%h", s, pcm_o, e); end
      if (overrun_o !== 1'b1) begin bad++; $display("[TB] FAIL bp_overrun sample=%0d got=%b want=1", s, overrun_o); end
    end
    repeat (3) @(negedge clock_i);
    total++;
    if (pcm_o !== e) begin bad++; $display("[TB] FAIL bp_hold got=%h want=%h", pcm_o, e); end
    clear_dut();
    @(negedge clock_i);
    total += 2;
    if (valid_o !== 1'b0) begin bad++; $display("[TB] FAIL enable_clear_valid got=%b want=0", valid_o); end
    if (overrun_o !== 1'b0) begin bad++; $display("[TB] FAIL enable_clear_overrun got=%b want=0", overrun_o); end
    ready_i = 1'b1;
  endtask

  task automatic test_mid_reset();
    int seen;
    ready_i = 1'b0;
    for (int i = 0; i < 17; i++) begin
      @(posedge clock_i); #1;
      done_i = 1'b1;
      data_i = 16'hFFFF;
      model_word(16'hFFFF);
    end
    @(posedge clock_i); #1;
    done_i = 1'b0;
    repeat (2) @(negedge clock_i);
    total += 3;
    if (valid_o !== 1'b1) begin bad++; $display("[TB] FAIL pre_reset_valid got=%b want=1", valid_o); end
    if (overrun_o !== 1'b1) begin bad++; $display("[TB] FAIL pre_reset_overrun got=%b want=1", overrun_o); end
    if (pcm_o !== 16'(exp_q[$])) begin bad++; $display("[TB] FAIL pre_reset_pcm got=%h want=%h", pcm_o, 16'(exp_q[$])); end
    @(posedge clock_i); #3;
    reset_n_i = 1'b0;
    #1;
    total += 3;
    if (pcm_o !== 16'h0000) begin bad++; $display("[TB] FAIL async_reset_pcm got=%h want=0000", pcm_o); end
    if (valid_o !== 1'b0) begin bad++; $display("[TB] FAIL async_reset_valid got=%b want=0", valid_o); end
    if (overrun_o !== 1'b0) begin bad++; $display("[TB] FAIL async_reset_overrun got=%b want=0", overrun_o); end
    @(posedge clock_i); #1;
    reset_n_i = 1'b1;
    ready_i   = 1'b1;
    model_reset();
    seen = 0;
    for (int w = 0; w < 15; w++) begin
      send_word(16'hFFFF);
      repeat (2) @(negedge clock_i);
      if (valid_o) seen++;
    end
    total++;
    if (seen != 0) begin bad++; $display("[TB] FAIL post_reset_warmup got=%0d samples want=0", seen); end
    send_word(16'hFFFF);
    repeat (2) @(negedge clock_i);
    total += 2;
    if (valid_o !== 1'b1) begin bad++; $display("[TB] FAIL post_reset_valid got=%b want=1", valid_o); end
    if (pcm_o !== 16'h0080) begin bad++; $display("[TB] FAIL post_reset_pcm got=%h want=0080", pcm_o); end
  endtask

  initial begin
    reset_n_i = 1'b0;
    enable_i  = 1'b1;
    done_i    = 1'b0;
    data_i    = 16'h0000;
    ready_i   = 1'b1;
    model_reset();
    test_reset();
    test_warmup();
    test_slide();
    test_back_to_back();
    test_simultaneous();
    test_backpressure();
    test_mid_reset();
    repeat (3) @(posedge clock_i);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
